// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: frame FSM encoding, prefix bytes and
// byte classification helpers used by the decoder and its input filter.
package ps2_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_LEN = 11;
  localparam int PS2_DATA_BITS = PS2_FRAME_LEN - 3;

  localparam int FLT_CNT_W = 8;

  typedef enum logic [1:0] {
    BYTE_CODE = 2'd0,
    BYTE_EXT  = 2'd1,
    BYTE_BRK  = 2'd2
  } byte_kind_t;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  function automatic byte_kind_t classify_byte(input logic [7:0] b);
    byte_kind_t k;
    k = BYTE_CODE;
    if (b == PS2_EXT_PREFIX) begin
      k = BYTE_EXT;
    end else if (b == PS2_BRK_PREFIX) begin
      k = BYTE_BRK;
    end
    return k;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Synchronises both PS/2 pins and debounces PS2_CLK; fall_tick pulses the cycle
// the filtered clock drops, FILTER_LEN+2 cycles after a clean raw falling edge.
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic CLK,
  input  logic ARST,
  input  logic PS2_CLK,
  input  logic PS2_DATA,
  output logic data_s,
  output logic fall_tick
);

  localparam logic [FLT_CNT_W-1:0] FLT_LAST = FLT_CNT_W'(FILTER_LEN - 1);

  logic [1:0]           clk_sync;
  logic [1:0]           data_sync;
  logic                 clk_f;
  logic [FLT_CNT_W-1:0] flt_cnt;

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_f     <= 1'b1;
      flt_cnt   <= '0;
      fall_tick <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
      fall_tick <= 1'b0;
      // Any sample matching the current level restarts the run.
      if (clk_sync[1] != clk_f) begin
        if (flt_cnt == FLT_LAST) begin
          clk_f     <= clk_sync[1];
          flt_cnt   <= '0;
          fall_tick <= clk_f;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign data_s = data_sync[1];

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: frames bytes, checks parity/stop, strips E0/F0 prefixes.
// Events and error pulses land one cycle after the stop-bit fall_tick; no backpressure.
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int CNT_W          = 18
) (
  input  logic       CLK,
  input  logic       ARST,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] CODE,
  output logic       EXT,
  output logic       KEYUP,
  output logic       CODE_VALID,
  output logic [3:0] HEX0,
  output logic [3:0] HEX1,
  output logic       ERR_PARITY,
  output logic       ERR_FRAME,
  output logic       ERR_TIMEOUT
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       BIT_LAST = 3'(PS2_DATA_BITS - 1);

  logic             data_s;
  logic             fall_tick;
  logic [1:0]       state;
  logic [2:0]       bitcnt;
  logic [7:0]       shreg;
  logic             par_bit;
  logic [CNT_W-1:0] to_cnt;
  logic             ext_pend;
  logic             brk_pend;
  logic             timeout_hit;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .CLK      (CLK),
    .ARST     (ARST),
    .PS2_CLK  (PS2_CLK),
    .PS2_DATA (PS2_DATA),
    .data_s   (data_s),
    .fall_tick(fall_tick)
  );

  // A falling edge arriving on the expiry cycle keeps the frame alive.
  assign timeout_hit = (state != ST_IDLE) && (to_cnt == TO_LAST) && !fall_tick;

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE || fall_tick) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state       <= ST_IDLE;
      bitcnt      <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      CODE        <= '0;
      EXT         <= 1'b0;
      KEYUP       <= 1'b0;
      CODE_VALID  <= 1'b0;
      ERR_PARITY  <= 1'b0;
      ERR_FRAME   <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      CODE_VALID  <= 1'b0;
      ERR_PARITY  <= 1'b0;
      ERR_FRAME   <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
      if (fall_tick) begin
        case (state)
          ST_IDLE: begin
            if (!data_s) begin
              state  <= ST_DATA;
              bitcnt <= '0;
            end
          end
          ST_DATA: begin
            shreg  <= {data_s, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == BIT_LAST) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            par_bit <= data_s;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!odd_parity_ok(shreg, par_bit)) begin
              ERR_PARITY <= 1'b1;
              ext_pend   <= 1'b0;
              brk_pend   <= 1'b0;
            end else if (!data_s) begin
              ERR_FRAME <= 1'b1;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
            end else begin
              case (classify_byte(shreg))
                BYTE_EXT: ext_pend <= 1'b1;
                BYTE_BRK: brk_pend <= 1'b1;
                default: begin
                  CODE       <= shreg;
                  EXT        <= ext_pend;
                  KEYUP      <= brk_pend;
                  CODE_VALID <= 1'b1;
                  ext_pend   <= 1'b0;
                  brk_pend   <= 1'b0;
                end
              endcase
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (timeout_hit) begin
        ERR_TIMEOUT <= 1'b1;
        state       <= ST_IDLE;
        ext_pend    <= 1'b0;
        brk_pend    <= 1'b0;
      end
    end
  end

  assign HEX0 = CODE[3:0];
  assign HEX1 = CODE[7:4];

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed bench for ps2_rx_decoder with a shortened PS/2 bit period and timeout.
module tb_ps2_rx_decoder;

  localparam int F    = 8;
  localparam int T    = 500;
  localparam int CW   = 10;
  localparam int HALF = 40;
  localparam int LAT  = F + 3;

  logic       CLK = 1'b0;
  logic       ARST = 1'b1;
  logic       PS2_CLK = 1'b1;
  logic       PS2_DATA = 1'b1;
  logic [7:0] CODE;
  logic       EXT, KEYUP, CODE_VALID;
  logic [3:0] HEX0, HEX1;
  logic       ERR_PARITY, ERR_FRAME, ERR_TIMEOUT;

  ps2_rx_decoder #(
    .FILTER_LEN(F),
    .TIMEOUT_CYCLES(T),
    .CNT_W(CW)
  ) dut (
    .CLK(CLK), .ARST(ARST), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .CODE(CODE), .EXT(EXT), .KEYUP(KEYUP), .CODE_VALID(CODE_VALID),
    .HEX0(HEX0), .HEX1(HEX1),
    .ERR_PARITY(ERR_PARITY), .ERR_FRAME(ERR_FRAME), .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int cv_n = 0, par_n = 0, frm_n = 0, to_n = 0, tick_n = 0;
  int cv_cyc = 0, err_cyc = 0, fall_cyc = 0;
  int checks = 0, passes = 0;

  always @(negedge CLK) begin
    if (CODE_VALID)  begin cv_n++;  cv_cyc = cyc;  end
    if (ERR_PARITY)  begin par_n++; err_cyc = cyc; end
    if (ERR_FRAME)   begin frm_n++; err_cyc = cyc; end
    if (ERR_TIMEOUT) begin to_n++;  err_cyc = cyc; end
    if (dut.fall_tick) tick_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic flip_par,
                                        input logic stop);
    return {stop, (~^b) ^ flip_par, b, 1'b0};
  endfunction

  // Bits first..last of fr; a 7-cycle clock glitch precedes bit glitch_at's fall.
  task automatic send_bits(input logic [10:0] fr, input int first, input int last,
                           input int glitch_at);
    for (int i = first; i <= last; i++) begin
      PS2_DATA = fr[i];
      if (i == glitch_at) begin
        repeat (10) @(negedge CLK);
        PS2_CLK = 1'b0;
        repeat (7) @(negedge CLK);
        PS2_CLK = 1'b1;
        repeat (HALF - 17) @(negedge CLK);
      end else begin
        repeat (HALF) @(negedge CLK);
      end
      PS2_CLK  = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(negedge CLK);
      PS2_CLK = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(frame(b, 1'b0, 1'b1), 0, 10, -1);
  endtask

  int c0, p0, f0, t0, k0;

  task automatic snap();
    c0 = cv_n; p0 = par_n; f0 = frm_n; t0 = to_n; k0 = tick_n;
  endtask

  initial begin
    #600us;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_code", CODE, 8'h00);
    chk("rst_flags", {EXT, KEYUP, CODE_VALID}, 3'b000);
    chk("rst_hex", {HEX1, HEX0}, 8'h00);
    chk("rst_errs", {ERR_PARITY, ERR_FRAME, ERR_TIMEOUT}, 3'b000);
    ARST = 1'b0;
    repeat (5) @(negedge CLK);

    // Plain make code 1C
    snap();
    send_byte(8'h1C);
    chk("1c_cv", cv_n - c0, 1);
    chk("1c_lat", cv_cyc - fall_cyc, LAT);
    chk("1c_ticks", tick_n - k0, 11);
    chk("1c_code", CODE, 8'h1C);
    chk("1c_flags", {EXT, KEYUP}, 2'b00);
    chk("1c_hex1", HEX1, 4'h1);
    chk("1c_hex0", HEX0, 4'hC);

    // Break F0 1C
    snap();
    send_byte(8'hF0);
    chk("f0_no_cv", cv_n - c0, 0);
    send_byte(8'h1C);
    chk("brk_cv", cv_n - c0, 1);
    chk("brk_code", CODE, 8'h1C);
    chk("brk_flags", {EXT, KEYUP}, 2'b01);

    // Extended break E0 F0 75, then plain 1C
    snap();
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk("ebrk_cv", cv_n - c0, 1);
    chk("ebrk_code", CODE, 8'h75);
    chk("ebrk_flags", {EXT, KEYUP}, 2'b11);
    send_byte(8'h1C);
    chk("after_ebrk_flags", {EXT, KEYUP}, 2'b00);

    // Reversed prefix order F0 E0 6B
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_byte(8'h6B);
    chk("rev_code", CODE, 8'h6B);
    chk("rev_flags", {EXT, KEYUP}, 2'b11);

    // Bad parity: pulse only, outputs held
    snap();
    send_bits(frame(8'h1C, 1'b1, 1'b1), 0, 10, -1);
    chk("par_err", par_n - p0, 1);
    chk("par_lat", err_cyc - fall_cyc, LAT);
    chk("par_no_cv", cv_n - c0, 0);
    chk("par_hold", {CODE, EXT, KEYUP}, {8'h6B, 2'b11});

    // Stop bit 0: frame error only
    snap();
    send_bits(frame(8'h2A, 1'b0, 1'b0), 0, 10, -1);
    chk("frm_err", frm_n - f0, 1);
    chk("frm_no_par", par_n - p0, 0);
    chk("frm_no_cv", cv_n - c0, 0);

    // Error clears a pending break
    snap();
    send_byte(8'hF0);
    send_bits(frame(8'h1C, 1'b1, 1'b1), 0, 10, -1);
    send_byte(8'h1C);
    chk("clr_cv", cv_n - c0, 1);
    chk("clr_keyup", {CODE, KEYUP}, {8'h1C, 1'b0});

    // Glitches while idle with data low
    snap();
    PS2_DATA = 1'b0;
    repeat (20) @(negedge CLK);
    PS2_CLK = 1'b0;
    @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (20) @(negedge CLK);
    PS2_CLK = 1'b0;
    repeat (7) @(negedge CLK);
    PS2_CLK = 1'b1;
    repeat (30) @(negedge CLK);
    chk("idle_glitch_ticks", tick_n - k0, 0);
    chk("idle_glitch_state", dut.state, 2'd0);
    PS2_DATA = 1'b1;
    repeat (10) @(negedge CLK);

    // Glitch inside the data phase
    snap();
    send_bits(frame(8'h5A, 1'b0, 1'b1), 0, 10, 4);
    chk("data_glitch_ticks", tick_n - k0, 11);
    chk("data_glitch_code", CODE, 8'h5A);
    chk("data_glitch_cv", cv_n - c0, 1);

    // Partial frame then silence
    snap();
    send_bits(frame(8'h33, 1'b0, 1'b1), 0, 4, -1);
    for (int k = 0; k < 2 * T && to_n == t0; k++) @(negedge CLK);
    chk("to_pulse", to_n - t0, 1);
    chk("to_lat", err_cyc - fall_cyc, LAT + T);
    chk("to_no_cv", cv_n - c0, 0);
    repeat (5) @(negedge CLK);
    send_byte(8'h24);
    chk("after_to_code", CODE, 8'h24);
    chk("after_to_cv", cv_n - c0, 1);

    // Reset after five data bits of F0
    send_byte(8'hE0);
    send_byte(8'h24);
    chk("pre_rst_ext", EXT, 1'b1);
    send_bits(frame(8'hF0, 1'b0, 1'b1), 0, 5, -1);
    ARST = 1'b1;
    repeat (2) @(negedge CLK);
    ARST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_code", CODE, 8'h00);
    chk("mid_rst_flags", {EXT, KEYUP, HEX1, HEX0}, 10'h000);
    snap();
    send_bits(frame(8'hF0, 1'b0, 1'b1), 6, 10, -1);
    chk("rest_ignored", (cv_n - c0) + (par_n - p0) + (frm_n - f0), 0);
    chk("rest_state", dut.state, 2'd0);
    send_byte(8'h1C);
    chk("post_rst_code", CODE, 8'h1C);
    chk("post_rst_flags", {EXT, KEYUP}, 2'b00);
    chk("post_rst_cv", cv_n - c0, 1);

    repeat (10) @(negedge CLK);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx_decoder.md
Name: ps2_rx_decoder

Overview:
Parametrised PS/2 keyboard receiver clocked from the system clock CLK. PS2_CLK and PS2_DATA are asynchronous inputs that are oversampled, synchronised and glitch-filtered. The block frames 11-bit PS/2 packets, checks odd parity and the stop bit, and strips the E0 (extended) and F0 (break) prefixes. It emits one qualified scancode event per key action to the game-control logic, plus error pulses and a bus timeout.

Parameters:
FILTER_LEN, 8, consecutive identical PS2_CLK samples required before the filtered level changes (range 1..255)
TIMEOUT_CYCLES, 200000, CLK cycles allowed between falling edges inside a frame before it is aborted (2 ms at 100 MHz)
CNT_W, 18, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
CLK  in  1  system clock; all state is updated on its rising edge
ARST  in  1  asynchronous reset, active-high
PS2_CLK  in  1  raw PS/2 clock pin, asynchronous
PS2_DATA  in  1  raw PS/2 data pin, asynchronous
CODE  out  8  last accepted scancode, prefix bytes removed
EXT  out  1  CODE was preceded by E0
KEYUP  out  1  CODE was preceded by F0 (key release)
CODE_VALID  out  1  one-cycle pulse when CODE, EXT and KEYUP update
HEX0  out  4  CODE[3:0]
HEX1  out  4  CODE[7:4]
ERR_PARITY  out  1  one-cycle pulse on parity failure
ERR_FRAME  out  1  one-cycle pulse when the stop bit is 0
ERR_TIMEOUT  out  1  one-cycle pulse on frame abort

Behaviour:
- Reset: ARST=1 clears all registers asynchronously. All outputs read 0, FSM is in IDLE, prefix flags are clear, synchronisers and filter hold 1 (bus idle). Reset mid-frame discards the partial byte with no error pulse.
- Input conditioning:
  - PS2_CLK and PS2_DATA each pass through two flip-flops.
  - The filtered clock toggles only after FILTER_LEN consecutive synchronised samples differ from its current value. Any mismatch restarts the count.
  - fall_tick is a one-cycle strobe on a 1->0 transition of the filtered clock. Data is sampled from the synchronised PS2_DATA in the same cycle.
- Frame FSM (states IDLE, DATA, PARITY, STOP), advancing on fall_tick only:
  - IDLE: sample 0 -> DATA with bitcnt=0. Sample 1 -> remain in IDLE, no error.
  - DATA: shift the sample in LSB-first. bitcnt increments; after bitcnt=7 -> PARITY.
  - PARITY: the sample is stored. -> STOP.
  - STOP: evaluate, then -> IDLE.
    - Odd-parity failure (XOR of 8 data bits and parity bit equals 0) -> ERR_PARITY pulse. Parity takes priority when both checks fail.
    - Otherwise stop bit 0 -> ERR_FRAME pulse.
    - Either error discards the byte and clears both prefix flags.
- Timeout: the counter clears on every fall_tick and in IDLE, and increments otherwise. At TIMEOUT_CYCLES while not in IDLE: ERR_TIMEOUT pulse, FSM -> IDLE, prefix flags cleared. If a fall_tick and the timeout occur in the same cycle, the fall_tick wins.
- Prefix decode on a good byte b:
  - b=E0: set ext_pend, no event.
  - b=F0: set brk_pend, no event.
  - Any other byte (including E1, AA, FA): CODE<=b, EXT<=ext_pend, KEYUP<=brk_pend, CODE_VALID=1 for one cycle, then both flags clear.
  - Sequences E0 F0 xx and F0 E0 xx both yield EXT=1, KEYUP=1.
- Latency: CODE_VALID and every error pulse assert on the CLK edge after the fall_tick of the stop bit. That is FILTER_LEN+3 CLK cycles after the raw stop-bit falling edge.
- CODE, EXT, KEYUP, HEX0 and HEX1 hold their values until the next CODE_VALID. Error pulses do not alter them.
- Back-to-back frames need no idle gap; a start bit may follow the stop bit immediately.

Decomposition:
- Shared package ps2_pkg: FSM state encoding, constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0, frame length 11.
- One sub-module, ps2_filter: two-flop synchroniser for both pins, PS2_CLK debounce counter, fall_tick generation. Outputs: data_s, fall_tick.
- Top module: FSM, shift register, parity/stop check, timeout counter, prefix flags, output registers.

Test Plan:
- Bench setup: CLK=100 MHz, PS2_CLK=12.5 kHz (4000 CLK cycles per half-period).
- Frame 0x1C (odd parity bit=0, stop=1) -> one CODE_VALID; CODE=8'h1C, EXT=0, KEYUP=0, HEX1=4'h1, HEX0=4'hC.
- Bytes F0,1C -> exactly one CODE_VALID, after the second frame; CODE=8'h1C, KEYUP=1, EXT=0.
- Bytes E0,F0,75 -> one CODE_VALID; CODE=8'h75, EXT=1, KEYUP=1. A following 1C gives EXT=0, KEYUP=0.
- Byte 0x1C with parity bit flipped -> ERR_PARITY pulse, no CODE_VALID, CODE unchanged. Frame with stop=0 -> ERR_FRAME only. Bytes F0 then bad-parity 1C then 1C -> KEYUP=0 on the final event.
- PS2_CLK 1-cycle and 7-cycle low glitches during IDLE and DATA -> no fall_tick, no state change. A 4-bit partial frame then silence -> ERR_TIMEOUT exactly TIMEOUT_CYCLES after the last filtered edge; the next full frame decodes correctly.
- ARST pulse mid-frame after 5 data bits -> all outputs 0. Remaining bits of that frame are ignored until a valid start bit; the subsequent frame decodes correctly.
